// File: rtl/axi_mem_master_port.sv
// CPU memory port to AXI4 master bridge: one outstanding request, single-beat
// writes or INCR read bursts, with response and beat-count error reporting.
module axi_mem_master_port #(
  parameter  int ADDR_BITS = 32,
  parameter  int DATA_BITS = 32,
  parameter  int ID_BITS   = 4,
  parameter  int ID_VALUE  = 0,
  parameter  int LEN_BITS  = 4,
  localparam int STRB_BITS = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic [STRB_BITS-1:0] req_strb,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 done,
  output logic                 err,
  output logic [ID_BITS-1:0]   axi_arid,
  output logic [ADDR_BITS-1:0] axi_araddr,
  output logic [LEN_BITS-1:0]  axi_arlen,
  output logic [2:0]           axi_arsize,
  output logic [1:0]           axi_arburst,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  input  logic [ID_BITS-1:0]   axi_rid,
  input  logic [DATA_BITS-1:0] axi_rdata,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rlast,
  input  logic                 axi_rvalid,
  output logic                 axi_rready,
  output logic [ID_BITS-1:0]   axi_awid,
  output logic [ADDR_BITS-1:0] axi_awaddr,
  output logic [LEN_BITS-1:0]  axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [DATA_BITS-1:0] axi_wdata,
  output logic [STRB_BITS-1:0] axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [ID_BITS-1:0]   axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready
);

  localparam int                   SIZE_VAL  = $clog2(STRB_BITS);
  localparam logic [ADDR_BITS-1:0] ADDR_MASK = ~ADDR_BITS'(STRB_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t                 state_r, next_s;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [LEN_BITS-1:0]    len_r, beat_r;
  logic [STRB_BITS-1:0]   strb_r;
  logic [DATA_BITS-1:0]   wdata_r;
  logic                   err_r, aw_done_r, w_done_r;
  logic accept_s, done_s, err_s, rdata_valid_s, beat_err_s;
  logic arvalid_s, rready_s, awvalid_s, wvalid_s, bready_s;
  logic unused_s;

  assign unused_s = ^{axi_rid, axi_bid, axi_rresp[0], axi_bresp[0]};

  // State register; async reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Next-state, handshake strobes and completion reporting
  always_comb begin
    next_s        = state_r;
    accept_s      = 1'b0;
    done_s        = 1'b0;
    err_s         = 1'b0;
    rdata_valid_s = 1'b0;
    beat_err_s    = 1'b0;
    arvalid_s     = 1'b0;
    rready_s      = 1'b0;
    awvalid_s     = 1'b0;
    wvalid_s      = 1'b0;
    bready_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (!req_write)                 next_s = RADDR;
          else if (req_strb != '0)        next_s = WADDR;
          else begin
            // empty-strobe write completes without touching the bus
            done_s = 1'b1;
            next_s = IDLE;
          end
        end else begin
          next_s = IDLE;
        end
      end
      RADDR: begin
        arvalid_s = 1'b1;
        if (axi_arready) next_s = RDATA;
        else             next_s = RADDR;
      end
      RDATA: begin
        rready_s = 1'b1;
        if (axi_rvalid) begin
          rdata_valid_s = 1'b1;
          beat_err_s    = axi_rresp[1] |
                          (axi_rlast ? (beat_r != len_r) : (beat_r == len_r));
          if (axi_rlast) begin
            done_s = 1'b1;
            err_s  = err_r | beat_err_s;
            next_s = IDLE;
          end else begin
            next_s = RDATA;
          end
        end else begin
          next_s = RDATA;
        end
      end
      WADDR: begin
        awvalid_s = ~aw_done_r;
        wvalid_s  = ~w_done_r;
        if ((aw_done_r | axi_awready) && (w_done_r | axi_wready)) next_s = WRESP;
        else                                                      next_s = WADDR;
      end
      WRESP: begin
        bready_s = 1'b1;
        if (axi_bvalid) begin
          done_s = 1'b1;
          err_s  = axi_bresp[1];
          next_s = IDLE;
        end else begin
          next_s = WRESP;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // Request latch, beat counter, sticky error and write-channel flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r    <= '0;
      len_r     <= '0;
      strb_r    <= '0;
      wdata_r   <= '0;
      beat_r    <= '0;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (accept_s) begin
      addr_r    <= req_addr & ADDR_MASK;
      len_r     <= req_len;
      strb_r    <= req_strb;
      wdata_r   <= req_wdata;
      beat_r    <= '0;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (rdata_valid_s) begin
        beat_r <= beat_r + LEN_BITS'(1);
        err_r  <= err_r | beat_err_s;
      end
      if (state_r == WADDR && next_s == WRESP) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else if (state_r == WADDR) begin
        aw_done_r <= aw_done_r | axi_awready;
        w_done_r  <= w_done_r | axi_wready;
      end
    end
  end

  assign busy        = (state_r != IDLE);
  assign done        = done_s;
  assign err         = err_s;
  assign rdata_valid = rdata_valid_s;
  assign rdata       = rdata_valid_s ? axi_rdata : '0;

  // Payloads are zeroed whenever their channel is not valid
  assign axi_arvalid = arvalid_s;
  assign axi_arid    = arvalid_s ? ID_BITS'(ID_VALUE) : '0;
  assign axi_araddr  = arvalid_s ? addr_r : '0;
  assign axi_arlen   = arvalid_s ? len_r : '0;
  assign axi_arsize  = arvalid_s ? 3'(SIZE_VAL) : 3'd0;
  assign axi_arburst = arvalid_s ? 2'b01 : 2'b00;
  assign axi_rready  = rready_s;
  assign axi_awvalid = awvalid_s;
  assign axi_awid    = awvalid_s ? ID_BITS'(ID_VALUE) : '0;
  assign axi_awaddr  = awvalid_s ? addr_r : '0;
  assign axi_awlen   = '0;
  assign axi_awsize  = awvalid_s ? 3'(SIZE_VAL) : 3'd0;
  assign axi_awburst = awvalid_s ? 2'b01 : 2'b00;
  assign axi_wvalid  = wvalid_s;
  assign axi_wdata   = wvalid_s ? wdata_r : '0;
  assign axi_wstrb   = wvalid_s ? strb_r : '0;
  assign axi_wlast   = wvalid_s;
  assign axi_bready  = bready_s;

endmodule

// File: doc/axi_mem_master_port.md
# axi_mem_master_port

Parametrised bridge between one CPU memory port (instruction or data) and one AXI4 master interface on the bus. It accepts a single outstanding request, issues single-beat writes or INCR bursts of 1–2^LEN_BITS read beats, and streams read data back to the CPU. Byte strobes, configurable widths and a response-error flag are supported. Two instances replace the fixed per-port wrappers: one for IM, with the write side tied off, and one for DM.

## Interface
- ADDR_BITS, 32, AXI/CPU byte-address width
- DATA_BITS, 32, data width (multiple of 8); STRB_BITS = DATA_BITS/8
- ID_BITS, 4, AXI ID width
- ID_VALUE, 0, constant driven on ARID/AWID
- LEN_BITS, 4, burst-length field width (AXI4 AxLEN subset)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present; held until done
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_BITS  byte address; low log2(STRB_BITS) bits ignored (forced 0)
- req_len  in  LEN_BITS  read beats minus 1; ignored for writes
- req_strb  in  STRB_BITS  byte enables, active-high (write only)
- req_wdata  in  DATA_BITS  write data
- busy  out  1  transaction in flight (CPU stall)
- rdata  out  DATA_BITS  read beat data, valid with rdata_valid
- rdata_valid  out  1  one pulse per accepted R beat
- done  out  1  one-cycle pulse when the transaction completes
- err  out  1  with done: any RRESP/BRESP[1] set, or beat-count mismatch
- AXI master: ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out, ARREADY in; RID/RDATA/RRESP/RLAST/RVALID in, RREADY out; AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in; WDATA/WSTRB/WLAST/WVALID out, WREADY in; BID/BRESP/BVALID in, BREADY out. Widths come from the parameters.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE: a request is accepted when req_valid=1. On acceptance, addr, len, strb, wdata and write are latched into registers.
  - Read: next state RADDR.
  - Write with strb≠0: next state WADDR.
  - Write with strb==0: no bus access; done=1 combinationally in the same cycle; stay in IDLE.
- RADDR: ARVALID=1 with ARADDR=latched addr, ARLEN=latched len, ARSIZE=log2(STRB_BITS), ARBURST=INCR (2'b01). ARREADY moves to RDATA.
- RDATA: RREADY=1. Each RVALID asserts rdata_valid, drives rdata=RDATA and increments the beat counter. RLAST produces done and returns to IDLE.
- Beat mismatch: if RLAST arrives at beat ≠ len, or beat len arrives without RLAST, err is set. On beat len without RLAST, the bridge keeps draining until RLAST and flags err.
- WADDR: AWVALID and WVALID rise together, with AWLEN=0, WLAST=1, WSTRB=latched strb, WDATA=latched wdata. Each valid drops independently after its own handshake; aw_done and w_done flags track this. The state moves to WRESP when both are done, including the case where both complete in the same cycle.
- WRESP: BREADY=1. BVALID produces done and returns to IDLE.
- err accumulation: OR of RRESP[1] over all beats plus the mismatch flag, or BRESP[1]. Cleared on acceptance.
- RID and BID are not checked.
- All AXI payload outputs are driven to 0 when their valid is low.

## Timing
- Reset (async): state IDLE. ARVALID, AWVALID, WVALID, RREADY, BREADY, busy, done, rdata_valid, err = 0. ARADDR, AWADDR, WDATA, WSTRB, rdata = 0. Counters and flags = 0.
- Reset mid-transaction drops every valid/ready immediately. No completion is reported.
- busy=1 in every state except IDLE.
- done and rdata_valid are combinational from the AXI handshake in the completion cycle. The CPU must drop or change req_valid in the cycle after done; a held req_valid is re-accepted as a new request.
- Minimum read latency (acceptance to done, 1 beat, zero-wait slave): 2 cycles. For N beats: 1 + N cycles.
- Minimum write latency: 2 cycles (AW and W same cycle, BVALID the cycle after).
- AxVALID is never withdrawn before its ready; payload stays stable while valid is high.

## Test plan
- Single read, addr 0x0000_1004, len 0, slave returns 0xDEADBEEF with OKAY:
  - ARADDR=0x1004, ARLEN=0 for one cycle;
  - rdata_valid and done the same cycle as RVALID;
  - rdata=0xDEADBEEF, err=0.
- Burst read, len 3, ARREADY delayed 2 cycles, RVALID gaps:
  - exactly 4 rdata_valid pulses in order;
  - done on the 4th with RLAST;
  - err=0.
- Write, addr 0x2000, strb 4'b0011, data 0x1234_5678:
  - AWREADY 1 cycle before WREADY; WVALID held until WREADY;
  - WSTRB=4'b0011, WLAST=1;
  - BRESP=SLVERR produces done=1 with err=1.
- Write with strb 0: done in the acceptance cycle; no AWVALID or WVALID ever; busy stays 0.
- Burst read, len 1, slave asserts RLAST on beat 0: done after 1 beat with err=1.
- Reset asserted in RDATA between beats:
  - all outputs 0 asynchronously;
  - the following read completes normally with err=0.
